digit_code_seq: RTL

DIGIT_CODE_SEQ -- requirements
Module: digit_code_seq

---
 rtl/digit_code_pkg.sv | 39 +++
 rtl/btn_debounce.sv | 60 ++++++
 rtl/digit_code_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/digit_code_pkg.sv
// ============================================================================
// Module   : digit_code_pkg
// Brief    : State enumeration and 3-bit segment codes for digit_code_seq.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package digit_code_pkg;

   typedef enum logic [2:0] {
      ST_BLANK = 3'd0,
      ST_D1    = 3'd1,
      ST_D2    = 3'd2,
      ST_D3    = 3'd3,
      ST_D4    = 3'd4
   } state_e;

   // Code bit order is {MSB, B, LSB}.
   localparam logic [2:0] CODE_BLANK = 3'b000;
   localparam logic [2:0] CODE_D1    = 3'b110;
   localparam logic [2:0] CODE_D2    = 3'b001;
   localparam logic [2:0] CODE_D3    = 3'b011;
   localparam logic [2:0] CODE_D4    = 3'b101;

   function automatic logic [2:0] state_code(input state_e s);
      logic [2:0] code;
      case (s)
         ST_D1:   code = CODE_D1;
         ST_D2:   code = CODE_D2;
         ST_D3:   code = CODE_D3;
         ST_D4:   code = CODE_D4;
         default: code = CODE_BLANK;
      endcase
      return code;
   endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Brief    : 2-flop synchronizer, counting debouncer and one-cycle rise pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic pulse_o
);

   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic       sync1_q, sync2_q;
   logic       deb_q, deb_d;
   logic       deb_dly_q;
   logic       pulse_q;
   logic [7:0] cnt_q, cnt_d;

   // Any cycle where the synchronized input agrees with deb_q restarts the run.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_q     <= 1'b0;
         deb_dly_q <= 1'b0;
         pulse_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= btn_i;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         pulse_q   <= deb_q & ~deb_dly_q;
         cnt_q     <= cnt_d;
      end
   end

   assign pulse_o = pulse_q;

endmodule

`default_nettype wire

// File: rtl/digit_code_seq.sv
// ============================================================================
// Module   : digit_code_seq
// Brief    : Button-stepped BLANK/D1..D4 sequencer driving a 7-seg code.
//            Optional auto-step prescaler: define DIGIT_SEQ_AUTO_STEP_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module digit_code_seq
   import digit_code_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int AUTO_DIV        = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_next,
   input  logic btn_clr,
   input  logic run,
   input  logic auto,
   output logic MSB,
   output logic B,
   output logic LSB,
   output logic valid,
   output logic wrap
);

   logic       step_pulse, clr_pulse;
   logic       step_any;
   state_e     state_q, state_d;
   logic [2:0] code_q;
   logic       valid_q;
   logic       wrap_q, wrap_d;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_next),
      .pulse_o (step_pulse)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_clr),
      .pulse_o (clr_pulse)
   );

`ifdef DIGIT_SEQ_AUTO_STEP_EN
   localparam int PW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(AUTO_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic          auto_tick;

   assign auto_tick = auto & run & (presc_q == PRESC_LAST);

   always_comb begin
      presc_d = presc_q + 1'b1;
      if (!auto || !run || clr_pulse || (presc_q == PRESC_LAST)) begin
         presc_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   // OR-merging means a coincident manual step and tick advance only once.
   assign step_any = step_pulse | auto_tick;
`else
   logic unused_auto;
   assign unused_auto = auto;
   assign step_any    = step_pulse;
`endif

   always_comb begin
      state_d = state_q;
      wrap_d  = 1'b0;
      if (clr_pulse) begin
         state_d = ST_BLANK;
      end else if (step_any && run) begin
         case (state_q)
            ST_BLANK: state_d = ST_D1;
            ST_D1:    state_d = ST_D2;
            ST_D2:    state_d = ST_D3;
            ST_D3:    state_d = ST_D4;
            ST_D4: begin
               state_d = ST_D1;
               wrap_d  = 1'b1;
            end
            default:  state_d = ST_BLANK;
         endcase
      end
   end

   // Outputs are registered from the next state so they move on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BLANK;
         code_q  <= CODE_BLANK;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= state_code(state_d);
         valid_q <= (state_d != ST_BLANK);
         wrap_q  <= wrap_d;
      end
   end

   assign MSB   = code_q[2];
   assign B     = code_q[1];
   assign LSB   = code_q[0];
   assign valid = valid_q;
   assign wrap  = wrap_q;

endmodule

`default_nettype wire
